// File: rtl/buffer_ring.sv
// buffer_ring: ring-buffer FIFO between a four-phase ready/done source and sink, optional line mode.
// Define BUFFER_RING_SYNC_EN to pass ready_in and done_out through 2-flop synchronisers.
module buffer_ring #(
  parameter int                       DATA_BITWIDTH = 8,
  parameter int                       DEPTH         = 16,
  parameter bit                       LINE_MODE     = 1'b0,
  parameter logic [DATA_BITWIDTH-1:0] TERM          = DATA_BITWIDTH'(8'h0A),
  parameter bit                       DROP_ON_FULL  = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic [DATA_BITWIDTH-1:0] data_in,
  input  logic                     ready_in,
  output logic                     done_in,
  output logic [DATA_BITWIDTH-1:0] data_out,
  output logic                     ready_out,
  input  logic                     done_out,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);
  localparam int            AW       = $clog2(DEPTH);
  localparam int            PW       = AW + 1;
  localparam logic [PW-1:0] FULL_CNT = PW'(DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  typedef enum logic       {I_IDLE, I_ACK} in_st_t;
  typedef enum logic [1:0] {O_IDLE, O_WAIT, O_REL} out_st_t;

  logic ready_in_s, done_out_s;

`ifdef BUFFER_RING_SYNC_EN
  logic [1:0] rin_sync_q, rin_sync_d, dout_sync_q, dout_sync_d;

  always_comb begin
    rin_sync_d  = {rin_sync_q[0], ready_in};
    dout_sync_d = {dout_sync_q[0], done_out};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rin_sync_q  <= '0;
      dout_sync_q <= '0;
    end else begin
      rin_sync_q  <= rin_sync_d;
      dout_sync_q <= dout_sync_d;
    end
  end

  assign ready_in_s = rin_sync_q[1];
  assign done_out_s = dout_sync_q[1];
`else
  assign ready_in_s = ready_in;
  assign done_out_s = done_out;
`endif

  logic [DATA_BITWIDTH-1:0] mem_q [DEPTH];
  in_st_t                   in_st_q, in_st_d;
  out_st_t                  out_st_q, out_st_d;
  logic [PW-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, cm_ptr_q, cm_ptr_d;
  logic                     done_in_q, done_in_d, ready_out_q, ready_out_d;
  logic                     overflow_q, overflow_d;
  logic [DATA_BITWIDTH-1:0] data_out_q, data_out_d;
  logic                     wr_en, pop, full;

  assign count = wr_ptr_q - rd_ptr_q;
  assign full  = (count == FULL_CNT);
  assign pop   = (out_st_q == O_WAIT) && done_out_s;

  always_comb begin
    in_st_d     = in_st_q;
    out_st_d    = out_st_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cm_ptr_d    = cm_ptr_q;
    done_in_d   = done_in_q;
    ready_out_d = ready_out_q;
    overflow_d  = overflow_q;
    data_out_d  = data_out_q;
    wr_en       = 1'b0;

    case (out_st_q)
      O_IDLE: if (cm_ptr_q != rd_ptr_q) begin
        data_out_d  = mem_q[rd_ptr_q[AW-1:0]];
        ready_out_d = 1'b1;
        out_st_d    = O_WAIT;
      end
      O_WAIT: if (done_out_s) begin
        rd_ptr_d    = rd_ptr_q + PTR_ONE;
        ready_out_d = 1'b0;
        out_st_d    = O_REL;
      end
      O_REL:   if (!done_out_s) out_st_d = O_IDLE;
      default: out_st_d = O_IDLE;
    endcase

    // A pop on this edge frees the head slot, so a full buffer can still take the write.
    case (in_st_q)
      I_IDLE: if (ready_in_s) begin
        if (!full || pop) begin
          wr_en     = 1'b1;
          wr_ptr_d  = wr_ptr_q + PTR_ONE;
          done_in_d = 1'b1;
          in_st_d   = I_ACK;
        end else if (DROP_ON_FULL) begin
          overflow_d = 1'b1;
          done_in_d  = 1'b1;
          in_st_d    = I_ACK;
        end
      end
      I_ACK: if (!ready_in_s) begin
        done_in_d = 1'b0;
        in_st_d   = I_IDLE;
      end
      default: in_st_d = I_IDLE;
    endcase

    if (!LINE_MODE) begin
      cm_ptr_d = wr_ptr_d;
    end else if (wr_en && (data_in == TERM || (wr_ptr_d - rd_ptr_d) == FULL_CNT)) begin
      cm_ptr_d = wr_ptr_d;
    end

    if (flush) begin
      in_st_d     = I_IDLE;
      out_st_d    = O_IDLE;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      cm_ptr_d    = '0;
      done_in_d   = 1'b0;
      ready_out_d = 1'b0;
      overflow_d  = 1'b0;
      data_out_d  = '0;
      wr_en       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_st_q     <= I_IDLE;
      out_st_q    <= O_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cm_ptr_q    <= '0;
      done_in_q   <= 1'b0;
      ready_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      data_out_q  <= '0;
    end else begin
      in_st_q     <= in_st_d;
      out_st_q    <= out_st_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cm_ptr_q    <= cm_ptr_d;
      done_in_q   <= done_in_d;
      ready_out_q <= ready_out_d;
      overflow_q  <= overflow_d;
      data_out_q  <= data_out_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= data_in;
  end

  assign done_in   = done_in_q;
  assign ready_out = ready_out_q;
  assign data_out  = data_out_q;
  assign overflow  = overflow_q;
endmodule
